// File: rtl/leg_if.sv
// leg_if: start/busy/done request and result bundle for leg_solver.
interface leg_if #(parameter int W = 8);
    logic         start;
    logic [W-1:0] r;
    logic [W-1:0] x;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         exact;
    logic         err;
    modport master (output start, r, x, input busy, done, y, exact, err);
    modport slave  (input start, r, x, output busy, done, y, exact, err);
endinterface

// File: rtl/leg_solver.sv
// leg_solver: y = floor(sqrt(r*r - x*x)), one root bit per cycle, start/busy/done handshake.
module leg_solver #(parameter int W = 8) (
    input logic clk,
    input logic rst_n,
    leg_if.slave s
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, CALC, ROOT, FIN} state_t;
    state_t         state, state_nx;
    logic [W-1:0]   r_q, x_q, root, y_q;
    logic [2*W-1:0] diff, r_ext, x_ext;
    logic [W+1:0]   rem, cur, trial;
    logic [CW-1:0]  cnt;
    logic           err_q, ge, done_q, exact_q, err_o;
    assign r_ext = {{W{1'b0}}, r_q};
    assign x_ext = {{W{1'b0}}, x_q};
    always_comb begin
        state_nx = (state == IDLE) ? (s.start ? CALC : IDLE) :
                   (state == CALC) ? ROOT :
                   (state == ROOT) ? ((cnt == '0) ? FIN : ROOT) : IDLE;
        cur   = {rem[W-1:0], diff[2*W-1:2*W-2]};
        trial = {root, 2'b01};
        ge    = cur >= trial;
    end
    // FIN holds the last root for one edge so results publish W+2 edges after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            r_q     <= '0;
            x_q     <= '0;
            diff    <= '0;
            rem     <= '0;
            root    <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            y_q     <= '0;
            exact_q <= 1'b0;
            err_o   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= state == FIN;
            if (state == IDLE && s.start) begin
                r_q <= s.r;
                x_q <= s.x;
            end else if (state == CALC) begin
                diff  <= (x_q > r_q) ? '0 : r_ext * r_ext - x_ext * x_ext;
                err_q <= x_q > r_q;
                rem   <= '0;
                root  <= '0;
                cnt   <= CW'(W - 1);
            end else if (state == ROOT) begin
                rem  <= ge ? cur - trial : cur;
                root <= {root[W-2:0], ge};
                diff <= diff << 2;
                cnt  <= cnt - 1'b1;
            end else if (state == FIN) begin
                y_q     <= root;
                exact_q <= (rem == '0) && !err_q;
                err_o   <= err_q;
            end
        end
    end
    assign s.busy  = state != IDLE;
    assign s.done  = done_q;
    assign s.y     = y_q;
    assign s.exact = exact_q;
    assign s.err   = err_o;
endmodule
